// File: rtl/bmf_sampler_pkg.sv
// Shared definitions for the BMF error sampler.
// Holds the sequencer state encoding, the Galois LFSR constants and
// small arithmetic helpers used by the sampler datapath.
package bmf_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Add two values and clamp the result at max_val. The 33-bit
  // intermediate keeps the carry so nothing ever wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_val}) return max_val;
    return s[31:0];
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/bmf_popcount.sv
// Combinational population count of the registered mismatch vector.
// Ports:
//   vec   - input vector, NUM_OUT bits wide (1..16)
//   count - number of ones in vec, 5 bits (max 16)
module bmf_popcount #(
  parameter int NUM_OUT = 5
) (
  input  logic [NUM_OUT-1:0] vec,
  output logic [4:0]         count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      count = count + 5'(vec[i]);
    end
  end

endmodule

// File: rtl/bmf_err_sampler.sv
// Sequencer and error-metric engine for a BMF-partitioned approximate
// sub-circuit. Drives one vector per cycle into the exact and approximate
// partition instances and accumulates mismatch count, Hamming-distance
// sum and worst-case Hamming distance.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start, abort    - begin a run (IDLE/DONE only) / stop current run
//   mode_exh        - 1 = exhaustive sweep, 0 = LFSR random sampling
//   num_samples     - sample count in LFSR mode (latched at start)
//   seed            - LFSR seed (latched at start, 0 selects LFSR_SEED)
//   dut_in          - vector driven to both partition instances
//   exact_out       - exact partition response
//   approx_out      - approximate partition response
//   busy, done      - run in progress / results final
//   mismatch_cnt    - samples with any differing output bit
//   hd_sum          - saturating sum of per-sample Hamming distances
//   hd_max          - worst per-sample Hamming distance
module bmf_err_sampler
  import bmf_sampler_pkg::*;
#(
  parameter int          NUM_IN    = 10,
  parameter int          NUM_OUT   = 5,
  parameter int          CNT_W     = 16,
  parameter int          SUM_W     = 20,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode_exh,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic [15:0]        seed,
  output logic [NUM_IN-1:0]  dut_in,
  input  logic [NUM_OUT-1:0] exact_out,
  input  logic [NUM_OUT-1:0] approx_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [SUM_W-1:0]   hd_sum,
  output logic [4:0]         hd_max
);

  // The sample index must hold both num_samples and 2^NUM_IN.
  localparam int IDX_W = (CNT_W > NUM_IN) ? CNT_W + 1 : NUM_IN + 1;
  localparam logic [31:0] MIS_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] SUM_MAX = 32'((64'd1 << SUM_W) - 64'd1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [NUM_IN-1:0]  dut_in_q, dut_in_d;
  logic [NUM_OUT-1:0] xor_q, xor_d;
  logic               xor_vld_q, xor_vld_d;
  logic [CNT_W-1:0]   mismatch_q, mismatch_d;
  logic [SUM_W-1:0]   hd_sum_q, hd_sum_d;
  logic [4:0]         hd_max_q, hd_max_d;

  logic [4:0]         pop_cnt;
  logic [15:0]        seed_eff;
  logic [15:0]        lfsr_next;

  bmf_popcount #(.NUM_OUT(NUM_OUT)) u_popcount (
    .vec   (xor_q),
    .count (pop_cnt)
  );

  assign seed_eff  = (seed == 16'd0) ? LFSR_SEED : seed;
  assign lfsr_next = lfsr_step(lfsr_q);

  // Next-state logic. Stage 2 accumulation is computed first so that a
  // start in IDLE/DONE can override it with the cleared values. Abort
  // suppresses both the stage-1 capture and the stage-2 update so the
  // in-flight sample never reaches the accumulators.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    n_d        = n_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    dut_in_d   = dut_in_q;
    xor_d      = xor_q;
    xor_vld_d  = 1'b0;
    mismatch_d = mismatch_q;
    hd_sum_d   = hd_sum_q;
    hd_max_d   = hd_max_q;

    if (xor_vld_q && !abort) begin
      mismatch_d = CNT_W'(sat_add(32'(mismatch_q),
                                  (xor_q != '0) ? 32'd1 : 32'd0, MIS_MAX));
      hd_sum_d   = SUM_W'(sat_add(32'(hd_sum_q), 32'(pop_cnt), SUM_MAX));
      if (pop_cnt > hd_max_q) hd_max_d = pop_cnt;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          mode_d     = mode_exh;
          n_d        = mode_exh ? (IDX_W'(1) << NUM_IN) : IDX_W'(num_samples);
          idx_d      = IDX_W'(1);
          lfsr_d     = seed_eff;
          dut_in_d   = mode_exh ? '0 : seed_eff[NUM_IN-1:0];
          mismatch_d = '0;
          hd_sum_d   = '0;
          hd_max_d   = '0;
          state_d    = (!mode_exh && num_samples == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          xor_d     = exact_out ^ approx_out;
          xor_vld_d = 1'b1;
          // The run ends on the last vector, so the exhaustive counter
          // never has to wrap.
          if (idx_q == n_q) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (mode_q) begin
              dut_in_d = dut_in_q + NUM_IN'(1);
            end else begin
              lfsr_d   = lfsr_next;
              dut_in_d = lfsr_next[NUM_IN-1:0];
            end
          end
        end
      end
      ST_DRAIN: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      lfsr_q     <= '0;
      dut_in_q   <= '0;
      xor_q      <= '0;
      xor_vld_q  <= 1'b0;
      mismatch_q <= '0;
      hd_sum_q   <= '0;
      hd_max_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      dut_in_q   <= dut_in_d;
      xor_q      <= xor_d;
      xor_vld_q  <= xor_vld_d;
      mismatch_q <= mismatch_d;
      hd_sum_q   <= hd_sum_d;
      hd_max_q   <= hd_max_d;
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign mismatch_cnt = mismatch_q;
  assign hd_sum       = hd_sum_q;
  assign hd_max       = hd_max_q;

endmodule

// File: tb/tb_bmf_err_sampler.sv
// Scoreboard bench for bmf_err_sampler. A stimulus process issues runs and
// pushes the reference-model result; a monitor pops it when done rises.
module tb_bmf_err_sampler;

  typedef struct {
    int mis;
    int sum;
    int mx;
    int busyCycles;
    bit chkVec;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        modeExh = 1'b0;
  logic [15:0] numSamples = '0;
  logic [15:0] seed = '0;
  logic [9:0]  dutIn;
  logic [4:0]  exactOut;
  logic [4:0]  approxOut;
  logic        busy;
  logic        done;
  logic [15:0] mismatchCnt;
  logic [19:0] hdSum;
  logic [4:0]  hdMax;

  logic        start8 = 1'b0;
  logic        abort8 = 1'b0;
  logic        modeExh8 = 1'b0;
  logic [15:0] numSamples8 = '0;
  logic [15:0] seed8 = '0;
  logic [9:0]  dutIn8;
  logic [4:0]  exactOut8;
  logic [4:0]  approxOut8;
  logic        busy8;
  logic        done8;
  logic [15:0] mismatchCnt8;
  logic [7:0]  hdSum8;
  logic [4:0]  hdMax8;

  int errMode = 0;
  int testsRun = 0;
  int testsFailed = 0;

  exp_t       expQ[$];
  logic [9:0] vecQ[$];

  always #5 clk = ~clk;

  bmf_err_sampler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_exh(modeExh),
    .num_samples(numSamples), .seed(seed), .dut_in(dutIn),
    .exact_out(exactOut), .approx_out(approxOut), .busy(busy), .done(done),
    .mismatch_cnt(mismatchCnt), .hd_sum(hdSum), .hd_max(hdMax)
  );

  bmf_err_sampler #(.SUM_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .mode_exh(modeExh8),
    .num_samples(numSamples8), .seed(seed8), .dut_in(dutIn8),
    .exact_out(exactOut8), .approx_out(approxOut8), .busy(busy8), .done(done8),
    .mismatch_cnt(mismatchCnt8), .hd_sum(hdSum8), .hd_max(hdMax8)
  );

  // Stand-in exact partition: an arbitrary fixed 10-in/5-out function.
  function automatic logic [4:0] exactF(input logic [9:0] v);
    logic [4:0] a;
    a = v[4:0] + v[9:5];
    return a ^ {v[9], v[0], v[5], v[2], v[7]};
  endfunction

  // Stand-in approximate partition, with the error pattern chosen by mode.
  function automatic logic [4:0] approxF(input logic [9:0] v, input int m);
    logic [4:0] e;
    e = exactF(v);
    case (m)
      1: return ~e;
      2: return e ^ 5'b00001;
      3: return (v == 10'h3FF) ? (e ^ 5'b00111) : e;
      4: return (v[2:0] == 3'd0) ? (e ^ {v[9:8], v[3], v[6], v[1]}) : e;
      default: return e;
    endcase
  endfunction

  function automatic logic [15:0] galoisNext(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  assign exactOut   = exactF(dutIn);
  assign approxOut  = approxF(dutIn, errMode);
  assign exactOut8  = exactF(dutIn8);
  assign approxOut8 = ~exactF(dutIn8);

  // Reference model: walk the vector list a run should produce and score
  // it with plain integer arithmetic and clamping.
  task automatic runModel(input bit m, input int ns, input logic [15:0] sd,
                          input int em, input int sumMax, input bit pushVec,
                          output exp_t r);
    int n;
    logic [15:0] l;
    logic [9:0] v;
    logic [4:0] x;
    n = m ? 1024 : ns;
    l = (sd == 16'd0) ? 16'hACE1 : sd;
    v = '0;
    r.mis = 0; r.sum = 0; r.mx = 0;
    r.busyCycles = n + 1;
    r.chkVec = pushVec && (n > 0);
    for (int k = 0; k < n; k++) begin
      v = m ? 10'(k) : l[9:0];
      x = exactF(v) ^ approxF(v, em);
      if (x != 0 && r.mis < 65535) r.mis++;
      r.sum = (r.sum + $countones(x) > sumMax) ? sumMax : r.sum + $countones(x);
      if ($countones(x) > r.mx) r.mx = $countones(x);
      if (r.chkVec) vecQ.push_back(v);
      l = galoisNext(l);
    end
    if (r.chkVec) vecQ.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit m, input int ns, input logic [15:0] sd,
                               input int em, input bit pokeStart);
    exp_t r;
    int limit;
    errMode = em;
    runModel(m, ns, sd, em, 20'hFFFFF, 1'b1, r);
    expQ.push_back(r);
    @(negedge clk);
    modeExh = m; numSamples = 16'(ns); seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    limit = r.busyCycles + 20;
    for (int c = 0; c < limit && !done; c++) begin
      start = pokeStart && (c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Monitor: counts busy cycles, compares dut_in against the expected
  // vector list, and checks the metrics when done rises.
  int busyCnt = 0;
  int vecErr = 0;
  bit donePrev = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      busyCnt = 0; vecErr = 0; donePrev = 1'b0;
    end else begin
      if (busy) begin
        busyCnt++;
        if (expQ.size() > 0 && expQ[0].chkVec) begin
          if (vecQ.size() == 0) vecErr++;
          else if (vecQ.pop_front() != dutIn) vecErr++;
        end
      end
      if (done && !donePrev) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          cur = expQ.pop_front();
          checkOutput("mismatch_cnt", int'(mismatchCnt), cur.mis);
          checkOutput("hd_sum", int'(hdSum), cur.sum);
          checkOutput("hd_max", int'(hdMax), cur.mx);
          checkOutput("busy_cycles", busyCnt, cur.busyCycles);
          if (cur.chkVec) checkOutput("dut_in_seq", vecErr + vecQ.size(), 0);
        end
        vecQ.delete();
        vecErr = 0;
        busyCnt = 0;
      end else if (!busy && !done) begin
        busyCnt = 0;
      end
      donePrev = done;
    end
  end

  initial begin
    exp_t r8;
    repeat (3) @(negedge clk);
    checkOutput("rst_dut_in", int'(dutIn), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_mismatch", int'(mismatchCnt), 0);
    checkOutput("rst_hd_sum", int'(hdSum), 0);
    checkOutput("rst_hd_max", int'(hdMax), 0);
    rst = 1'b0;

    applyStimulus(1'b1, 0, 16'h0000, 0, 1'b0);
    applyStimulus(1'b1, 0, 16'h0000, 1, 1'b0);
    applyStimulus(1'b0, 100, 16'h0000, 2, 1'b0);
    applyStimulus(1'b0, 0, 16'h1234, 1, 1'b0);

    // abort and start together in DONE: abort wins and the results freeze.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_start_done", int'(done), 0);
    checkOutput("abort_start_busy", int'(busy), 0);

    // Aborted exhaustive run: no scoreboard entry, partial counts still 0.
    errMode = 3;
    modeExh = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_mismatch", int'(mismatchCnt), 0);
    checkOutput("abort_hd_sum", int'(hdSum), 0);
    applyStimulus(1'b1, 0, 16'h0000, 3, 1'b1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, int'($urandom_range(1, 300)),
                    (i == 0) ? 16'h0000 : 16'($urandom),
                    int'($urandom_range(0, 4)), i[0]);
    end
    applyStimulus(1'b1, 0, 16'h0000, 4, 1'b0);

    // Narrow accumulator instance: hd_sum must clamp at 255.
    runModel(1'b0, 100, 16'h0000, 1, 255, 1'b0, r8);
    modeExh8 = 1'b0; numSamples8 = 16'd100; seed8 = 16'h0000; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 0; c < 200 && !done8; c++) @(negedge clk);
    checkOutput("sat_done", int'(done8), 1);
    checkOutput("sat_hd_sum", int'(hdSum8), r8.sum);
    checkOutput("sat_mismatch", int'(mismatchCnt8), r8.mis);
    checkOutput("sat_hd_max", int'(hdMax8), r8.mx);

    // Reset in the middle of a run leaves no residue.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrun_busy_before", int'(busy8), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_rst_busy", int'(busy8), 0);
    checkOutput("midrun_rst_done", int'(done8), 0);
    checkOutput("midrun_rst_dut_in", int'(dutIn8), 0);
    checkOutput("midrun_rst_mismatch", int'(mismatchCnt8), 0);
    checkOutput("midrun_rst_hd_sum", int'(hdSum8), 0);
    checkOutput("midrun_rst_hd_max", int'(hdMax8), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrun_idle_busy", int'(busy8), 0);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
